// File: rtl/persp_viewport_if.sv
// persp_viewport_if
//   Bundles the two handshake channels of the perspective/viewport stage:
//   the clip-space vertex bundle coming from the transform stage and the
//   screen-space triangle going to the rasterizer.
//
//   Upstream (transform -> viewport):
//     x_in/y_in/z_in/w_in [3:0][31:0]  clip-space Q16.16, entries 0..2 used
//     in_data_valid, done_in            bundle valid, end-of-stream flag
//     stall_out                         back-pressure to the transform stage
//   Downstream (viewport -> rasterizer):
//     sx_out/sy_out/sz_out [2:0][31:0]  screen-space Q16.16
//     out_data_valid, done_out          triangle valid, end-of-stream marker
//     stall_in                          rasterizer cannot accept
//   Status:
//     culled_count [15:0]               triangles dropped for w <= 0
//
//   modport slave  : the viewport block itself
//   modport master : the environment around it (transform + rasterizer)
interface persp_viewport_if;
    logic [3:0][31:0] x_in;
    logic [3:0][31:0] y_in;
    logic [3:0][31:0] z_in;
    logic [3:0][31:0] w_in;
    logic             in_data_valid;
    logic             done_in;
    logic             stall_in;

    logic [2:0][31:0] sx_out;
    logic [2:0][31:0] sy_out;
    logic [2:0][31:0] sz_out;
    logic             out_data_valid;
    logic             done_out;
    logic             stall_out;
    logic [15:0]      culled_count;

    modport master (
        output x_in, y_in, z_in, w_in, in_data_valid, done_in, stall_in,
        input  sx_out, sy_out, sz_out, out_data_valid, done_out, stall_out,
               culled_count
    );

    modport slave (
        input  x_in, y_in, z_in, w_in, in_data_valid, done_in, stall_in,
        output sx_out, sy_out, sz_out, out_data_valid, done_out, stall_out,
               culled_count
    );
endinterface

// File: rtl/persp_viewport.sv
// persp_viewport
//   Receives one clip-space triangle, culls it if any w <= 0, otherwise
//   performs nine perspective divides (x/w, y/w, z/w per vertex) on a single
//   shared restoring divider, maps the NDC results to screen space and holds
//   the triangle on the output until the rasterizer takes it.
//
//   Ports:
//     clock  - sole clock, all state changes on posedge
//     reset  - synchronous, active-high
//     vp     - persp_viewport_if.slave (vertex bundle in, triangle out,
//              stall_in/stall_out handshake, culled_count)
//
//   Parameters:
//     WIDTH, HEIGHT - screen size in pixels; scale factors are WIDTH/2, HEIGHT/2
//     FRAC          - fractional bits; the divider runs 32+FRAC iterations
module persp_viewport #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int FRAC   = 16
) (
    input  logic            clock,
    input  logic            reset,
    persp_viewport_if.slave vp
);

    localparam int          ITERS    = 32 + FRAC;
    localparam int          CW       = $clog2(ITERS);
    localparam logic [31:0] ONE      = 32'd1 << FRAC;
    localparam logic [31:0] SX_SCALE = 32'(WIDTH / 2);
    localparam logic [31:0] SY_SCALE = 32'(HEIGHT / 2);
    localparam logic [31:0] MAG_MAX  = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        CULL_DONE,
        DIV_LOAD,
        DIV_ITER,
        VIEWPORT,
        OUT
    } state_t;

    state_t state_q, state_d;

    // Latched input bundle
    logic [2:0][31:0] xl_q, yl_q, zl_q, wl_q;
    logic             done_l_q;

    // Divider state: dq_q shifts dividend bits out of the top while quotient
    // bits enter at the bottom.
    logic [ITERS-1:0] dq_q;
    logic [31:0]      rem_q;
    logic [31:0]      dvs_q;
    logic             neg_q;
    logic [CW-1:0]    iter_q;
    logic [1:0]       vtx_q;
    logic [1:0]       comp_q;

    logic [2:0][31:0] ndc_x_q, ndc_y_q, ndc_z_q;

    // Output registers
    logic [2:0][31:0] sx_q, sy_q, sz_q;
    logic             valid_q;
    logic             done_q;
    logic             stall_q;
    logic [15:0]      culled_q;

    // Entry 3 of each input vector is not part of a triangle.
    logic unused_entry3;
    assign unused_entry3 = ^{vp.x_in[3], vp.y_in[3], vp.z_in[3], vp.w_in[3]};

    // ---------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------
    logic cull;
    always_comb begin
        cull = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if ($signed(wl_q[i]) <= 32'sd0) cull = 1'b1;
        end
    end

    logic [31:0] num_sel, w_sel, num_abs, w_abs;
    always_comb begin
        w_sel = wl_q[vtx_q];
        case (comp_q)
            2'd0:    num_sel = xl_q[vtx_q];
            2'd1:    num_sel = yl_q[vtx_q];
            default: num_sel = zl_q[vtx_q];
        endcase
        num_abs = num_sel[31] ? -num_sel : num_sel;
        w_abs   = w_sel[31]   ? -w_sel   : w_sel;
    end

    // One restoring step. The remainder stays below the divisor, so the
    // shifted partial remainder needs only one extra bit.
    logic [32:0]      rem_sh;
    logic             fits;
    logic [31:0]      rem_nx;
    logic [ITERS-1:0] dq_nx;
    logic [31:0]      quot_mag, quot;
    always_comb begin
        rem_sh   = {rem_q, dq_q[ITERS-1]};
        fits     = rem_sh >= {1'b0, dvs_q};
        rem_nx   = fits ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
        dq_nx    = {dq_q[ITERS-2:0], fits};
        // Clamping the magnitude before negation gives 0x80000001 on the
        // negative side.
        quot_mag = (|dq_nx[ITERS-1:31]) ? MAG_MAX : dq_nx[31:0];
        quot     = neg_q ? -quot_mag : quot_mag;
    end

    logic last_iter, last_div;
    assign last_iter = (iter_q == CW'(ITERS - 1));
    assign last_div  = (vtx_q == 2'd2) && (comp_q == 2'd2);

    // Viewport map, 32-bit wraparound arithmetic
    logic [2:0][31:0] sx_v, sy_v, sz_v;
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            sx_v[i] = (ndc_x_q[i] + ONE) * SX_SCALE;
            sy_v[i] = (ONE - ndc_y_q[i]) * SY_SCALE;
            sz_v[i] = 32'($signed(ndc_z_q[i] + ONE) >>> 1);
        end
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (vp.in_data_valid) state_d = CHECK;
            CHECK: begin
                if (cull) state_d = done_l_q ? CULL_DONE : IDLE;
                else      state_d = DIV_LOAD;
            end
            CULL_DONE: state_d = IDLE;
            DIV_LOAD:  state_d = DIV_ITER;
            DIV_ITER:  if (last_iter) state_d = last_div ? VIEWPORT : DIV_LOAD;
            VIEWPORT:  state_d = OUT;
            OUT:       if (!vp.stall_in) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath and output registers
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            xl_q     <= '0;
            yl_q     <= '0;
            zl_q     <= '0;
            wl_q     <= '0;
            done_l_q <= 1'b0;
            dq_q     <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            iter_q   <= '0;
            vtx_q    <= '0;
            comp_q   <= '0;
            ndc_x_q  <= '0;
            ndc_y_q  <= '0;
            ndc_z_q  <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            sz_q     <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            stall_q  <= 1'b0;
            culled_q <= '0;
        end else begin
            // Flags are registered from the next state so they line up
            // exactly with the state they describe.
            stall_q <= (state_d != IDLE);
            valid_q <= (state_d == OUT);
            done_q  <= ((state_d == OUT) && done_l_q) || (state_d == CULL_DONE);

            case (state_q)
                IDLE: begin
                    if (vp.in_data_valid) begin
                        xl_q     <= vp.x_in[2:0];
                        yl_q     <= vp.y_in[2:0];
                        zl_q     <= vp.z_in[2:0];
                        wl_q     <= vp.w_in[2:0];
                        done_l_q <= vp.done_in;
                    end
                end
                CHECK: begin
                    if (cull) culled_q <= culled_q + 16'd1;
                    vtx_q  <= '0;
                    comp_q <= '0;
                end
                DIV_LOAD: begin
                    rem_q  <= '0;
                    dq_q   <= {num_abs, {FRAC{1'b0}}};
                    dvs_q  <= w_abs;
                    neg_q  <= num_sel[31] ^ w_sel[31];
                    iter_q <= '0;
                end
                DIV_ITER: begin
                    rem_q  <= rem_nx;
                    dq_q   <= dq_nx;
                    iter_q <= iter_q + CW'(1);
                    if (last_iter) begin
                        case (comp_q)
                            2'd0:    ndc_x_q[vtx_q] <= quot;
                            2'd1:    ndc_y_q[vtx_q] <= quot;
                            default: ndc_z_q[vtx_q] <= quot;
                        endcase
                        if (comp_q == 2'd2) begin
                            comp_q <= '0;
                            vtx_q  <= vtx_q + 2'd1;
                        end else begin
                            comp_q <= comp_q + 2'd1;
                        end
                    end
                end
                VIEWPORT: begin
                    sx_q <= sx_v;
                    sy_q <= sy_v;
                    sz_q <= sz_v;
                end
                default: ;
            endcase
        end
    end

    assign vp.sx_out         = sx_q;
    assign vp.sy_out         = sy_q;
    assign vp.sz_out         = sz_q;
    assign vp.out_data_valid = valid_q;
    assign vp.done_out       = done_q;
    assign vp.stall_out      = stall_q;
    assign vp.culled_count   = culled_q;

endmodule

// File: tb/tb_persp_viewport.sv
// tb_persp_viewport
//   Drives directed and random triangles into persp_viewport and checks every
//   cycle against a transaction-level model: expected screen coordinates come
//   from plain 64-bit arithmetic on the clip-space inputs, expected timing
//   from the cycle count since the accept edge.
`timescale 1ns/1ps
module tb_persp_viewport;
    localparam int WIDTH  = 640;
    localparam int HEIGHT = 480;
    localparam int FRAC   = 16;
    localparam logic [31:0] ONE = 32'h0001_0000;
    localparam int LAT = 443;

    typedef logic [2:0][31:0] vec3_t;

    logic clock = 1'b0;
    logic reset;

    persp_viewport_if vp();

    persp_viewport #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .FRAC(FRAC)) dut (
        .clock (clock),
        .reset (reset),
        .vp    (vp)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_ndc(input logic [31:0] n, input logic [31:0] w);
        longint unsigned an, aw, q;
        logic [31:0] r;
        an = n[31] ? (64'h1_0000_0000 - 64'(n)) : 64'(n);
        aw = w[31] ? (64'h1_0000_0000 - 64'(w)) : 64'(w);
        q  = (an << FRAC) / aw;
        if (q > 64'h7FFF_FFFF) q = 64'h7FFF_FFFF;
        r = q[31:0];
        return (n[31] ^ w[31]) ? (32'd0 - r) : r;
    endfunction

    function automatic logic [31:0] m_sx(input logic [31:0] ndc);
        logic [31:0] t;
        longint unsigned p;
        t = ndc + ONE;
        p = 64'(t) * 64'(WIDTH / 2);
        return p[31:0];
    endfunction

    function automatic logic [31:0] m_sy(input logic [31:0] ndc);
        logic [31:0] t;
        longint unsigned p;
        t = ONE - ndc;
        p = 64'(t) * 64'(HEIGHT / 2);
        return p[31:0];
    endfunction

    function automatic logic [31:0] m_sz(input logic [31:0] ndc);
        logic [31:0] t;
        t = ndc + ONE;
        return {t[31], t[31:1]};
    endfunction

    // ---------------- model state shared with compare process ----------------
    logic  tx_active = 1'b0;
    logic  tx_new    = 1'b0;
    logic  tx_cull, tx_done;
    vec3_t e_sx, e_sy, e_sz;
    int    exp_culled = 0;
    int    n_cyc = 0;
    int    pulses = 0;
    logic  prev_v = 1'b0;
    logic  ev, es, ed;
    int    stall_mode = 2;   // 0 random, 1 forced high, 2 forced low

    always begin
        @(negedge clock);
        #1;
        case (stall_mode)
            1:       vp.stall_in = 1'b1;
            2:       vp.stall_in = 1'b0;
            default: vp.stall_in = ($urandom_range(0, 2) == 0);
        endcase
    end

    // Compare process: outputs sampled 1 ns after each posedge. stall_in only
    // changes after negedges, so its value here is the one the edge saw.
    always begin
        @(posedge clock);
        #1;
        if (reset) begin
            tx_active  = 1'b0;
            tx_new     = 1'b0;
            exp_culled = 0;
            chk("rst out_data_valid", 32'(vp.out_data_valid), 0);
            chk("rst stall_out", 32'(vp.stall_out), 0);
            chk("rst done_out", 32'(vp.done_out), 0);
            chk("rst culled_count", 32'(vp.culled_count), 0);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rst sx_out[%0d]", i), vp.sx_out[i], 0);
                chk($sformatf("rst sy_out[%0d]", i), vp.sy_out[i], 0);
                chk($sformatf("rst sz_out[%0d]", i), vp.sz_out[i], 0);
            end
        end else begin
            ev = 1'b0; es = 1'b0; ed = 1'b0;
            if (tx_active) begin
                if (tx_new) begin
                    n_cyc  = 0;
                    tx_new = 1'b0;
                end else begin
                    n_cyc++;
                end
                if (tx_cull) begin
                    es = (n_cyc == 0) || (n_cyc == 1 && tx_done);
                    ed = (n_cyc == 1) && tx_done;
                    if (n_cyc == 1) exp_culled = (exp_culled + 1) & 16'hFFFF;
                    if ((n_cyc == 1 && !tx_done) || n_cyc == 2) tx_active = 1'b0;
                end else if (n_cyc > LAT && !vp.stall_in) begin
                    tx_active = 1'b0;
                end else begin
                    es = 1'b1;
                    ev = (n_cyc >= LAT);
                    ed = ev && tx_done;
                end
            end
            chk("stall_out", 32'(vp.stall_out), 32'(es));
            chk("out_data_valid", 32'(vp.out_data_valid), 32'(ev));
            chk("done_out", 32'(vp.done_out), 32'(ed));
            chk("culled_count", 32'(vp.culled_count), 32'(exp_culled));
            if (ev) begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("sx_out[%0d]", i), vp.sx_out[i], e_sx[i]);
                    chk($sformatf("sy_out[%0d]", i), vp.sy_out[i], e_sy[i]);
                    chk($sformatf("sz_out[%0d]", i), vp.sz_out[i], e_sz[i]);
                end
            end
        end
        if (vp.out_data_valid === 1'b1 && !prev_v) pulses++;
        prev_v = (vp.out_data_valid === 1'b1);
    end

    // ---------------- stimulus ----------------
    task automatic scramble_inputs();
        for (int i = 0; i < 4; i++) begin
            vp.x_in[i] = $urandom();
            vp.y_in[i] = $urandom();
            vp.z_in[i] = $urandom();
            vp.w_in[i] = $urandom();
        end
        vp.done_in = $urandom_range(0, 1);
    endtask

    // Presents a bundle and holds it until the model says the block is idle;
    // the following posedge is the accept edge.
    task automatic send(input vec3_t x, input vec3_t y, input vec3_t z,
                        input vec3_t w, input logic dn);
        int guard;
        @(negedge clock);
        vp.x_in = {32'($urandom()), x};
        vp.y_in = {32'($urandom()), y};
        vp.z_in = {32'($urandom()), z};
        vp.w_in = {32'($urandom()), w};
        vp.done_in = dn;
        vp.in_data_valid = 1'b1;
        guard = 0;
        while (tx_active && guard < 5000) begin
            @(negedge clock);
            guard++;
        end
        if (tx_active) begin
            total++;
            bad++;
            $display("FAIL send_wait: block still busy after %0d cycles", guard);
            vp.in_data_valid = 1'b0;
            return;
        end
        @(posedge clock);
        tx_cull = 1'b0;
        for (int i = 0; i < 3; i++)
            if ($signed(w[i]) <= 32'sd0) tx_cull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!tx_cull) begin
                e_sx[i] = m_sx(m_ndc(x[i], w[i]));
                e_sy[i] = m_sy(m_ndc(y[i], w[i]));
                e_sz[i] = m_sz(m_ndc(z[i], w[i]));
            end
        end
        tx_done   = dn;
        tx_new    = 1'b1;
        tx_active = 1'b1;
        @(negedge clock);
        vp.in_data_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while (tx_active && k < limit) begin
            @(negedge clock);
            k++;
        end
        if (tx_active) begin
            total++;
            bad++;
            $display("FAIL idle_wait: transaction open after %0d cycles", limit);
        end
        @(negedge clock);
    endtask

    function automatic logic [31:0] rand_w();
        case ($urandom_range(0, 9))
            0:       return $urandom_range(0, 1) ? 32'h0 : (32'h8000_0000 | $urandom());
            1:       return 32'($urandom_range(1, 15));
            default: return ($urandom() & 32'h7FFF_FFFF) | 32'h100;
        endcase
    endfunction

    function automatic logic [31:0] rand_n();
        logic [31:0] r;
        r = $urandom();
        return $signed(r) >>> $urandom_range(0, 16);
    endfunction

    vec3_t zero3, one3, vx, vy, vz, vw;
    int    p0;

    initial begin
        zero3 = '0;
        one3  = {ONE, ONE, ONE};
        reset = 1'b1;
        vp.in_data_valid = 1'b0;
        vp.stall_in = 1'b0;
        scramble_inputs();

        // Hand-computed points that pin the model itself
        chk("pin c1 sx", m_sx(m_ndc(32'h0, ONE)), 32'h0140_0000);
        chk("pin c1 sy", m_sy(m_ndc(32'h0, ONE)), 32'h00F0_0000);
        chk("pin c1 sz", m_sz(m_ndc(32'h0, ONE)), 32'h0000_8000);
        chk("pin c2 sx", m_sx(m_ndc(32'h0001_0000, 32'h0002_0000)), 32'h01E0_0000);
        chk("pin c2 sy", m_sy(m_ndc(32'hFFFF_0000, 32'h0002_0000)), 32'h0168_0000);
        chk("pin c2 sz", m_sz(m_ndc(32'h0001_0000, 32'h0002_0000)), 32'h0000_C000);
        chk("pin c6 sx+", m_sx(m_ndc(32'h0003_0000, 32'h0002_0000)), 32'h0320_0000);
        chk("pin c6 sx-", m_sx(m_ndc(32'hFFFD_0000, 32'h0002_0000)), 32'hFF60_0000);
        chk("pin c6 sat", m_ndc(32'h7FFF_0000, 32'h1), 32'h7FFF_FFFF);
        chk("pin c6 satn", m_ndc(32'h8001_0000, 32'h1), 32'h8000_0001);
        chk("pin c6 sz", m_sz(m_ndc(32'h7FFF_0000, 32'h1)), 32'hC000_7FFF);

        repeat (3) @(negedge clock);
        reset = 1'b0;

        // 1: origin triangle, single-cycle transfer
        stall_mode = 2;
        send(zero3, zero3, zero3, one3, 1'b0);
        wait_idle(1000);

        // 2: off-centre vertex 0
        vx = zero3; vy = zero3; vz = zero3; vw = one3;
        vx[0] = 32'h0001_0000; vy[0] = 32'hFFFF_0000; vz[0] = 32'h0001_0000; vw[0] = 32'h0002_0000;
        send(vx, vy, vz, vw, 1'b1);
        wait_idle(1000);

        // 3: culls, first with end-of-stream, then negative w
        vw = one3; vw[1] = 32'h0;
        send(zero3, zero3, zero3, vw, 1'b1);
        wait_idle(100);
        vw[1] = 32'hFFFF_0000;
        send(zero3, zero3, zero3, vw, 1'b0);
        wait_idle(100);
        chk("culled after case 3", 32'(vp.culled_count), 32'd2);

        // 4: rasterizer stalls 20 cycles; next bundle held meanwhile
        p0 = pulses;
        stall_mode = 1;
        send(zero3, zero3, zero3, one3, 1'b0);
        vx = zero3; vx[2] = 32'h0000_8000;
        fork
            begin
                repeat (LAT + 20) @(negedge clock);
                stall_mode = 2;
            end
            send(vx, zero3, zero3, one3, 1'b0);
        join
        wait_idle(1000);
        chk("case 4 transfers", 32'(pulses - p0), 32'd2);

        // 5: reset in the middle of a divide, then a clean triangle
        send(zero3, zero3, zero3, one3, 1'b0);
        repeat (100) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        send(zero3, zero3, zero3, one3, 1'b0);
        wait_idle(1000);

        // 6: out-of-frustum NDC and divider saturation
        vx = zero3; vz = zero3; vw = one3;
        vx[0] = 32'h0003_0000; vw[0] = 32'h0002_0000;
        vx[1] = 32'hFFFD_0000; vw[1] = 32'h0002_0000;
        vz[2] = 32'h7FFF_0000; vw[2] = 32'h0000_0001;
        send(vx, zero3, vz, vw, 1'b0);
        wait_idle(1000);

        // Random triangles with random rasterizer back-pressure
        stall_mode = 0;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 3; i++) begin
                vx[i] = rand_n();
                vy[i] = rand_n();
                vz[i] = rand_n();
                vw[i] = rand_w();
            end
            send(vx, vy, vz, vw, ($urandom_range(0, 3) == 0));
        end
        wait_idle(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
